pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register for the RISC-V pipeline: the next-generation replacement for the fixed-width inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle from one stage to the next with one-cycle latency.
- Supports valid/ready backpressure, synchronous flush that inserts a bubble, and a saturating stall counter.
- Control bits are forced low on bubbles, so a killed instruction can never assert RegWrite/MemWrite downstream.

---
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                             |
// | Description : Elastic pipeline-stage register with valid/ready           |
// |               backpressure, bubble-inserting flush, control-bit masking  |
// |               on bubbles and a saturating stall counter.                 |
// |               Optional macro PIPE_STAGE_SKID_EN adds a second (skid)     |
// |               entry and makes in_ready a function of state only.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy encoding; the SKID state only exists when the skid entry is built.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1
`ifdef PIPE_STAGE_SKID_EN
    ,
    ST_SKID  = 2'd2
`endif
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_out_valid;
  logic                w_in_fire;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;

  // Ready depends only on the state register, so out_ready never reaches in_ready.
  assign in_ready = (r_state != ST_SKID);
`else
  // Single-entry stage: can take a beat when empty or when the held beat leaves.
  assign in_ready = !w_out_valid || out_ready;
`endif

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid && in_ready;

  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  // Bubbles never carry live control bits (RegWrite/MemWrite etc.).
  assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign stall_cnt = r_stall_cnt;

  // Occupancy FSM and beat storage; flush overrides every same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
`ifdef PIPE_STAGE_SKID_EN
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
`endif
    end else if (flush) begin
      // Held beats are discarded; out_data keeps its last value on purpose.
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
            r_state     <= ST_FULL;
          end
        end
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_in_fire && out_ready) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new beat behind the held one.
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
            r_state     <= ST_SKID;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
`else
          // Without a skid entry an accepted beat implies out_ready is high.
          if (w_in_fire) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          if (out_ready) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_state     <= ST_FULL;
          end
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Count stalled output cycles, saturating at all-ones; flush cycles are not stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && !flush && (r_stall_cnt != C_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                          |
// | Description : Directed self-checking bench for pipe_stage_reg: reset,   |
// |               streaming, backpressure, flush, async reset, saturation.  |
// |               Expectations follow PIPE_STAGE_SKID_EN when defined.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic [31:0] stall_cnt;

  // Narrow-counter instance sharing the same stimulus
  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [7:0]  sat_out_data;
  logic [7:0]  sat_out_ctrl;
  logic [3:0]  sat_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(8), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_data   (in_data[7:0]),
    .in_ctrl   (in_ctrl),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_data  (sat_out_data),
    .out_ctrl  (sat_out_ctrl),
    .stall_cnt (sat_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    #2 rst_n  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_out_ctrl",  {56'd0, out_ctrl}, 64'd0);
    chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming 1..5 with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 64'(i);
      in_ctrl = 8'(i);
      step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_data",  out_data, 64'(i));
      chk("stream_ctrl",  {56'd0, out_ctrl}, 64'(i));
      chk("stream_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", {63'd0, out_valid}, 64'd0);
    chk("stream_drain_ctrl",  {56'd0, out_ctrl}, 64'd0);
    chk("stream_data_kept",   out_data, 64'd5);
    chk("stream_stall",       {32'd0, stall_cnt}, 64'd0);

    // Backpressure: 0xA then 0xB, out_ready low for 3 stalled cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    in_ctrl   = 8'h01;
    step();
    chk("bp_a_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_a_data",  out_data, 64'hA);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_full_ready", {63'd0, in_ready}, 64'd1);
`else
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
`endif
    in_data = 64'hB;
    in_ctrl = 8'h02;
    step();
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
    chk("bp_skid_ready", {63'd0, in_ready}, 64'd0);
`endif
    chk("bp_hold1_data", out_data, 64'hA);
    chk("bp_stall1",     {32'd0, stall_cnt}, 64'd1);
    step();
    chk("bp_hold2_data", out_data, 64'hA);
    chk("bp_stall2",     {32'd0, stall_cnt}, 64'd2);
    step();
    chk("bp_hold3_data", out_data, 64'hA);
    chk("bp_stall3",     {32'd0, stall_cnt}, 64'd3);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_b_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_b_data",  out_data, 64'hB);
    chk("bp_b_ctrl",  {56'd0, out_ctrl}, 64'h02);
    chk("bp_stall_final", {32'd0, stall_cnt}, 64'd3);
    step();
    chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with a beat presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h33;
    in_ctrl   = 8'hFF;
    step();
    chk("fl_full_ctrl", {56'd0, out_ctrl}, 64'hFF);
    flush   = 1'b1;
    in_data = 64'h44;
    in_ctrl = 8'h77;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ctrl",  {56'd0, out_ctrl}, 64'h00);
    chk("fl_data_kept", out_data, 64'h33);
    chk("fl_stall", {32'd0, stall_cnt}, 64'd3);
    step();
    chk("fl_no_ghost_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_no_ghost_data",  out_data, 64'h33);

    // Asynchronous reset mid-stream (SKID with the macro, FULL without)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 8'h0F;
    step();
    in_data = 64'h66;
    step();
    chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_data",  out_data, 64'd0);
    chk("ar_ctrl",  {56'd0, out_ctrl}, 64'd0);
    chk("ar_stall", {32'd0, stall_cnt}, 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    in_ctrl   = 8'h05;
    step();
    in_valid = 1'b0;
    chk("ar_first_valid", {63'd0, out_valid}, 64'd1);
    chk("ar_first_data",  out_data, 64'h77);
    chk("ar_first_ctrl",  {56'd0, out_ctrl}, 64'h05);
    step();
    chk("ar_alone_valid", {63'd0, out_valid}, 64'd0);

    // Saturation: one held beat, 20 stalled cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h99;
    in_ctrl   = 8'h03;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_14", {60'd0, sat_stall_cnt}, 64'd14);
      if (i == 15) chk("sat_15", {60'd0, sat_stall_cnt}, 64'd15);
    end
    chk("sat_hold",     {60'd0, sat_stall_cnt}, 64'd15);
    chk("sat_wide_cnt", {32'd0, stall_cnt}, 64'd20);
    chk("sat_valid",    {63'd0, out_valid}, 64'd1);
    chk("sat_data",     out_data, 64'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
